// File: rtl/addsub_op_sequencer.sv
// rtl/addsub_op_sequencer.sv - operand/result sequencer wrapping a combinational W-bit add/sub unit
//
// Purpose:
//   Collects operand A, then operand B plus the operation select, from one
//   narrow valid/ready input stream. It presents the registered operands to an
//   external combinational add/sub unit, captures its sum/difference and
//   carry/borrow one cycle later, and offers the captured result on a
//   valid/ready output. One operation is in flight at a time.
//
// Optional feature (macro ADDSUB_ACCUM_EN):
//   defined   - accumulate mode. On each result handoff the captured result
//               becomes the next operand A and the FSM waits only for B + sel.
//               The carry/borrow is not chained. Only reset returns to GET_A.
//   undefined - every operation takes two input beats (A, then B + sel).
//
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  synchronous active-high reset
//   in_valid_i   in   1  input beat valid
//   in_ready_o   out  1  input beat accepted on in_valid_i && in_ready_o
//   in_data_i    in   W  operand (A on first beat, B on second)
//   in_sel_i     in   1  operation, sampled on the B beat: 0 add, 1 subtract
//   au_A_o       out  W  registered operand A to the add/sub unit
//   au_B_o       out  W  registered operand B to the add/sub unit
//   au_sel_o     out  1  registered operation select to the add/sub unit
//   au_S_i       in   W  sum/difference from the add/sub unit
//   au_C_i       in   1  carry (add) / borrow (subtract) from the add/sub unit
//   res_valid_o  out  1  captured result available
//   res_ready_i  in   1  downstream accepts the result
//   res_data_o   out  W  captured result
//   res_carry_o  out  1  captured carry/borrow
//   busy_o       out  1  high in every state except GET_A
//   op_count_o   out  8  results handed off, wraps 255 -> 0

module addsub_op_sequencer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         in_sel_i,
  output logic [W-1:0] au_A_o,
  output logic [W-1:0] au_B_o,
  output logic         au_sel_o,
  input  logic [W-1:0] au_S_i,
  input  logic         au_C_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic         res_carry_o,
  output logic         busy_o,
  output logic [7:0]   op_count_o
);

  localparam logic [1:0] S_GET_A = 2'd0;
  localparam logic [1:0] S_GET_B = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0] state;

  // Handshakes are pure state decodes so neither side sees a combinational
  // path from its own valid/ready back to the other's.
  assign in_ready_o  = (state == S_GET_A) || (state == S_GET_B);
  assign res_valid_o = (state == S_OUT);
  assign busy_o      = (state != S_GET_A);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_GET_A;
      au_A_o      <= '0;
      au_B_o      <= '0;
      au_sel_o    <= 1'b0;
      res_data_o  <= '0;
      res_carry_o <= 1'b0;
      op_count_o  <= 8'd0;
    end else begin
      case (state)
        S_GET_A: begin
          if (in_valid_i) begin
            au_A_o <= in_data_i;
            state  <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (in_valid_i) begin
            au_B_o   <= in_data_i;
            au_sel_o <= in_sel_i;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Operands have been stable on au_*_o for a full cycle; the unit's
          // outputs are settled and are captured as-is.
          res_data_o  <= au_S_i;
          res_carry_o <= au_C_i;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (res_ready_i) begin
            op_count_o <= op_count_o + 8'd1;
`ifdef ADDSUB_ACCUM_EN
            au_A_o <= res_data_o;
            state  <= S_GET_B;
`else
            state  <= S_GET_A;
`endif
          end
        end
        default: state <= S_GET_A;
      endcase
    end
  end

endmodule
